trig_fire_arbiter: RTL and testbench

Shares the single global trigger-output resource among the eight trigger-condition requesters (4LayersHit … Internal) on the `clk_adc` domain. It opens one fire window per accepted trigger and drives the shared output pulse. It accumulates every trigger bit that fires during the window into one bitstring, and queues a {bits, first-bit, timestamp} record in an 8-deep FIFO for slow-side readout.

---
 rtl/trig_fire_arbiter.sv | 174 +++++++++++++++++
 tb/tb_trig_fire_arbiter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/trig_fire_arbiter.sv
// ============================================================================
// Module   : trig_fire_arbiter
// Summary  : Arbitrates eight trigger requesters onto one fire output and queues
//            {bits, first, time} window records in a FIFO. Define TRIG_ARB_EDGE_EN
//            for rising-edge requests; without it, requests are level-sensitive.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module trig_fire_arbiter #(
    parameter int NTRIG = 8,
    parameter int TS_W  = 56,
    parameter int DEPTH = 8
) (
    input  logic              clk_adc,
    input  logic              rst,
    input  logic [NTRIG-1:0]  trig_req,
    input  logic [NTRIG-1:0]  trig_enable,
    input  logic [7:0]        dead_time,
    input  logic [5:0]        pulse_len,
    input  logic [TS_W-1:0]   timestamp,
    output logic              fire_out,
    output logic              busy,
    output logic              rec_valid,
    input  logic              rec_ready,
    output logic [NTRIG-1:0]  rec_bits,
    output logic [2:0]        rec_first,
    output logic [TS_W-1:0]   rec_time,
    output logic [3:0]        fifo_count,
    output logic [15:0]       overflow_count,
    input  logic              clear_counts
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = 1;
    localparam logic [3:0]     DEPTH_C  = 4'(DEPTH);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WINDOW = 2'd1;
    localparam logic [1:0] S_COMMIT = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [NTRIG-1:0] eff;
    logic [2:0]       first_idx;
    logic [NTRIG-1:0] bits_q;
    logic [2:0]       first_q;
    logic [TS_W-1:0]  time_q;
    logic [5:0]       pcnt_q;
    logic [7:0]       dcnt_q;
    logic             commit;

    logic [NTRIG-1:0] mem_bits_q  [DEPTH];
    logic [2:0]       mem_first_q [DEPTH];
    logic [TS_W-1:0]  mem_time_q  [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [3:0]       count_q;
    logic [15:0]      ovf_q;
    logic             push, pop, drop;

`ifdef TRIG_ARB_EDGE_EN
    logic [NTRIG-1:0] trig_req_q;

    always_ff @(posedge clk_adc) begin
        if (rst) trig_req_q <= '0;
        else     trig_req_q <= trig_req;
    end

    assign eff = trig_req & ~trig_req_q & trig_enable;
`else
    assign eff = trig_req & trig_enable;
`endif

    // Descending scan so the lowest set index is the one that sticks.
    always_comb begin
        first_idx = '0;
        for (int i = NTRIG - 1; i >= 0; i--) begin
            if (eff[i]) first_idx = 3'(i);
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (eff != '0) state_d = S_WINDOW;
            S_WINDOW: if (pcnt_q <= 6'd1 && dcnt_q <= 8'd1) state_d = S_COMMIT;
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != S_IDLE);
        fire_out = (state_q == S_WINDOW) && (pcnt_q != 6'd0);
        commit   = (state_q == S_COMMIT);
    end

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            bits_q  <= '0;
            first_q <= '0;
            time_q  <= '0;
            pcnt_q  <= '0;
            dcnt_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (eff != '0) begin
                        bits_q  <= eff;
                        first_q <= first_idx;
                        time_q  <= timestamp;
                        pcnt_q  <= (pulse_len == 6'd0) ? 6'd1 : pulse_len;
                        dcnt_q  <= (dead_time == 8'd0) ? 8'd1 : dead_time;
                    end
                end
                S_WINDOW: begin
                    bits_q <= bits_q | eff;
                    if (pcnt_q != 6'd0) pcnt_q <= pcnt_q - 6'd1;
                    if (dcnt_q != 8'd0) dcnt_q <= dcnt_q - 8'd1;
                end
                default: ;
            endcase
        end
    end

    // A pop in the commit cycle frees the head slot, so a full FIFO still accepts.
    assign pop  = rec_valid && rec_ready;
    assign push = commit && ((count_q < DEPTH_C) || pop);
    assign drop = commit && !push;

    always_ff @(posedge clk_adc) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
            case ({push, pop})
                2'b10:   count_q <= count_q + 4'd1;
                2'b01:   count_q <= count_q - 4'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_adc) begin
        if (push) begin
            mem_bits_q[wr_ptr_q]  <= bits_q;
            mem_first_q[wr_ptr_q] <= first_q;
            mem_time_q[wr_ptr_q]  <= time_q;
        end
    end

    always_ff @(posedge clk_adc) begin
        if (rst || clear_counts)           ovf_q <= '0;
        else if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
    end

    assign rec_valid      = (count_q != 4'd0);
    assign rec_bits       = rec_valid ? mem_bits_q[rd_ptr_q]  : '0;
    assign rec_first      = rec_valid ? mem_first_q[rd_ptr_q] : '0;
    assign rec_time       = rec_valid ? mem_time_q[rd_ptr_q]  : '0;
    assign fifo_count     = count_q;
    assign overflow_count = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_trig_fire_arbiter.sv
// ============================================================================
// Module   : tb_trig_fire_arbiter
// Summary  : Directed-vector bench; a queue scoreboard holds expected records
//            that a negedge monitor pops and checks whenever the DUT pops one.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_trig_fire_arbiter;

    typedef struct packed {
        logic [7:0]  bits;
        logic [2:0]  first;
        logic [55:0] t;
    } rec_t;

`ifdef TRIG_ARB_EDGE_EN
    localparam int HELD_RECS = 1;
`else
    localparam int HELD_RECS = 8;
`endif

    logic        clk;
    logic        rst;
    logic [7:0]  trig_req;
    logic [7:0]  trig_enable;
    logic [7:0]  dead_time;
    logic [5:0]  pulse_len;
    logic [55:0] ts;
    logic        fire_out;
    logic        busy;
    logic        rec_valid;
    logic        rec_ready;
    logic [7:0]  rec_bits;
    logic [2:0]  rec_first;
    logic [55:0] rec_time;
    logic [3:0]  fifo_count;
    logic [15:0] overflow_count;
    logic        clear_counts;

    int   vectors;
    int   miscompares;
    rec_t sb[$];
    rec_t mon_e;

    trig_fire_arbiter dut (
        .clk_adc        (clk),
        .rst            (rst),
        .trig_req       (trig_req),
        .trig_enable    (trig_enable),
        .dead_time      (dead_time),
        .pulse_len      (pulse_len),
        .timestamp      (ts),
        .fire_out       (fire_out),
        .busy           (busy),
        .rec_valid      (rec_valid),
        .rec_ready      (rec_ready),
        .rec_bits       (rec_bits),
        .rec_first      (rec_first),
        .rec_time       (rec_time),
        .fifo_count     (fifo_count),
        .overflow_count (overflow_count),
        .clear_counts   (clear_counts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            ts = ts + 56'd1;
        end
    endtask

    task automatic expect_rec(input logic [7:0] b, input logic [2:0] f, input logic [55:0] t);
        rec_t r;
        r.bits  = b;
        r.first = f;
        r.t     = t;
        sb.push_back(r);
    endtask

    // Monitor: every DUT pop is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst && rec_valid && rec_ready) begin
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL unexpected_record: got bits 0x%0h first %0d, required none",
                         rec_bits, rec_first);
            end else begin
                mon_e = sb.pop_front();
                chk("rec_bits",  64'(rec_bits),  64'(mon_e.bits));
                chk("rec_first", 64'(rec_first), 64'(mon_e.first));
                chk("rec_time",  64'(rec_time),  64'(mon_e.t));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        vectors      = 0;
        miscompares  = 0;
        rst          = 1'b1;
        trig_req     = '0;
        trig_enable  = 8'hFF;
        dead_time    = 8'd10;
        pulse_len    = 6'd4;
        ts           = 56'd0;
        rec_ready    = 1'b1;
        clear_counts = 1'b0;
        cyc(3);
        chk("reset_fire",     64'(fire_out),       64'd0);
        chk("reset_busy",     64'(busy),           64'd0);
        chk("reset_valid",    64'(rec_valid),      64'd0);
        chk("reset_count",    64'(fifo_count),     64'd0);
        chk("reset_overflow", 64'(overflow_count), 64'd0);
        chk("reset_bits",     64'(rec_bits),       64'd0);
        chk("reset_time",     64'(rec_time),       64'd0);
        rst = 1'b0;
        cyc(2);

        // Single request, D=10 P=4, timestamp 1000
        ts       = 56'd1000;
        trig_req = 8'h01;
        expect_rec(8'h01, 3'd0, 56'd1000);
        cyc(1);
        trig_req = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("single_fire_%0d", k), 64'(fire_out), (k <= 4) ? 64'd1 : 64'd0);
            chk($sformatf("single_busy_%0d", k), 64'(busy), 64'd1);
            cyc(1);
        end
        cyc(4);
        chk("single_valid_early", 64'(rec_valid), 64'd0);
        cyc(1);
        chk("single_valid",  64'(rec_valid),  64'd1);
        chk("single_count",  64'(fifo_count), 64'd1);
        cyc(3);
        chk("single_idle", 64'(busy), 64'd0);

        // Accumulation: bit3 at N, bit6 at N+5, bit7 at N+11 lands in COMMIT
        trig_req = 8'h08;
        expect_rec(8'h48, 3'd3, ts);
        cyc(1);
        trig_req = 8'h00;
        cyc(4);
        trig_req = 8'h40;
        cyc(1);
        trig_req = 8'h00;
        cyc(5);
        trig_req = 8'h80;
        cyc(1);
        trig_req = 8'h00;
        cyc(4);
        chk("accum_no_retrigger", 64'(busy), 64'd0);
        cyc(2);

        // Enable masking and first-index tie
        trig_enable = 8'hFE;
        trig_req    = 8'h03;
        expect_rec(8'h02, 3'd1, ts);
        cyc(1);
        trig_req = 8'h00;
        cyc(14);
        trig_enable = 8'hFF;

        // Overflow: 10 short windows with no readout
        rec_ready = 1'b0;
        dead_time = 8'd1;
        pulse_len = 6'd1;
        for (int i = 0; i < 10; i++) begin
            trig_req = 8'h01 << (i % 8);
            if (i < 8) expect_rec(8'h01 << (i % 8), 3'(i % 8), ts);
            cyc(1);
            trig_req = 8'h00;
            cyc(2);
        end
        chk("ovf_count_full", 64'(fifo_count),     64'd8);
        chk("ovf_dropped",    64'(overflow_count), 64'd2);

        // 11th drop coincides with clear_counts
        trig_req = 8'h10;
        cyc(1);
        trig_req = 8'h00;
        cyc(1);
        clear_counts = 1'b1;
        cyc(1);
        clear_counts = 1'b0;
        chk("ovf_clear_wins", 64'(overflow_count), 64'd0);
        chk("ovf_still_full", 64'(fifo_count),     64'd8);

        // Full FIFO with a pop in the COMMIT cycle
        trig_req = 8'h20;
        expect_rec(8'h20, 3'd5, ts);
        cyc(1);
        trig_req = 8'h00;
        cyc(1);
        rec_ready = 1'b1;
        cyc(1);
        rec_ready = 1'b0;
        chk("fullpop_count",    64'(fifo_count),     64'd8);
        chk("fullpop_overflow", 64'(overflow_count), 64'd0);
        rec_ready = 1'b1;
        cyc(10);
        chk("drain_count", 64'(fifo_count), 64'd0);

        // Reset in the middle of a D=20 window
        dead_time = 8'd20;
        pulse_len = 6'd4;
        trig_req  = 8'h01;
        cyc(1);
        trig_req = 8'h00;
        cyc(2);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("rstmid_fire",  64'(fire_out),   64'd0);
        chk("rstmid_busy",  64'(busy),       64'd0);
        chk("rstmid_count", 64'(fifo_count), 64'd0);
        cyc(25);
        chk("rstmid_no_rec", 64'(rec_valid), 64'd0);

        // Held request for 96 sampled edges, D=10 P=4
        dead_time = 8'd10;
        pulse_len = 6'd4;
        rec_ready = 1'b0;
        trig_req  = 8'h01;
        for (int i = 0; i < 96; i++) begin
`ifdef TRIG_ARB_EDGE_EN
            if (i == 0) expect_rec(8'h01, 3'd0, ts);
`else
            if (i % 12 == 0) expect_rec(8'h01, 3'd0, ts);
`endif
            cyc(1);
        end
        trig_req = 8'h00;
        cyc(15);
        chk("held_records",  64'(fifo_count),     64'(HELD_RECS));
        chk("held_overflow", 64'(overflow_count), 64'd0);
        rec_ready = 1'b1;
        cyc(12);
        chk("held_drained",   64'(fifo_count), 64'd0);
        chk("scoreboard_left", 64'(sb.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire
